logic_axi4_stream_demux_packet: RTL and testbench

Packet-aware AXI4-Stream demultiplexer. The first beat of each packet selects its destination, and that route is held until TLAST. It generalises the plain demux with:
- selectable routing field (TDEST / TUSER / TID);
- per-output registered slices;
- an unmapped-route policy (extract port or drop);
- saturating drop and packet counters.

It sits between a stream source and per-channel consumers in the stream fabric.

---
 rtl/logic_axi4_stream_demux_packet_pkg.sv | 38 +++
 rtl/logic_axi4_stream_demux_packet_slice.sv | 32 +++
 rtl/logic_axi4_stream_demux_packet.sv | 189 ++++++++++++++++++
 tb/tb_logic_axi4_stream_demux_packet.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_axi4_stream_demux_packet_pkg.sv
// rtl/logic_axi4_stream_demux_packet_pkg.sv - shared types and default route map for the packet demux
package logic_axi4_stream_demux_packet_pkg;

    typedef enum logic [1:0] {
        ROUTE_TDEST = 2'd0,
        ROUTE_TUSER = 2'd1,
        ROUTE_TID   = 2'd2
    } route_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } state_t;

    typedef enum logic {
        UNMAPPED_DROP    = 1'b0,
        UNMAPPED_EXTRACT = 1'b1
    } unmapped_t;

    // Route maps are carried as one flat vector; entry i occupies bits [i*width +: width].
    localparam int MAP_BITS_MAX = 1024;

    // Identity map: entry i matches field value i.
    function automatic logic [MAP_BITS_MAX-1:0] init_map(input int outputs, input int width);
        logic [MAP_BITS_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < outputs; i++) begin
            for (int b = 0; b < width; b++) begin
                if (i * width + b < MAP_BITS_MAX) begin
                    m[i * width + b] = ((i >> b) & 1) == 1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_demux_packet_slice.sv
// rtl/logic_axi4_stream_demux_packet_slice.sv - one-stage output register slice
module logic_axi4_stream_demux_packet_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] payload,
    output logic             tvalid,
    input  logic             tready,
    output logic [WIDTH-1:0] held
);

    // Valid flag: a load always wins, otherwise a completed handshake empties the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

    // Payload register needs no reset; it is only observed while tvalid is high.
    always_ff @(posedge clk) begin
        if (load) begin
            held <= payload;
        end
    end

endmodule

// File: rtl/logic_axi4_stream_demux_packet.sv
// rtl/logic_axi4_stream_demux_packet.sv - packet-aware stream demux with route lock, drop policy and counters
module logic_axi4_stream_demux_packet
    import logic_axi4_stream_demux_packet_pkg::*;
#(
    parameter int OUTPUTS       = 4,
    parameter int TDATA_BYTES   = 4,
    parameter int TDEST_WIDTH   = 1,
    parameter int TUSER_WIDTH   = 1,
    parameter int TID_WIDTH     = 1,
    parameter int ROUTE_MODE    = 0,
    parameter int MAP_WIDTH     = (ROUTE_MODE == 2) ? TID_WIDTH :
                                  (ROUTE_MODE == 1) ? TUSER_WIDTH : TDEST_WIDTH,
    parameter logic [MAP_BITS_MAX-1:0] MAP = init_map(OUTPUTS, MAP_WIDTH),
    parameter int UNMAPPED      = 0,
    parameter int COUNTER_WIDTH = 16,
    localparam int TXN          = OUTPUTS + UNMAPPED
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             rx_tvalid,
    output logic                             rx_tready,
    input  logic                             rx_tlast,
    input  logic [TDATA_BYTES*8-1:0]         rx_tdata,
    input  logic [TDATA_BYTES-1:0]           rx_tstrb,
    input  logic [TDATA_BYTES-1:0]           rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]           rx_tdest,
    input  logic [TUSER_WIDTH-1:0]           rx_tuser,
    input  logic [TID_WIDTH-1:0]             rx_tid,
    output logic [TXN-1:0]                   tx_tvalid,
    input  logic [TXN-1:0]                   tx_tready,
    output logic [TXN-1:0]                   tx_tlast,
    output logic [TXN*TDATA_BYTES*8-1:0]     tx_tdata,
    output logic [TXN*TDATA_BYTES-1:0]       tx_tstrb,
    output logic [TXN*TDATA_BYTES-1:0]       tx_tkeep,
    output logic [TXN*TDEST_WIDTH-1:0]       tx_tdest,
    output logic [TXN*TUSER_WIDTH-1:0]       tx_tuser,
    output logic [TXN*TID_WIDTH-1:0]         tx_tid,
    output logic [COUNTER_WIDTH-1:0]         dropped_packets,
    output logic [COUNTER_WIDTH-1:0]         routed_packets
);

    localparam int SEL_W = (TXN > 1) ? $clog2(TXN) : 1;
    localparam int DW    = TDATA_BYTES * 8;
    localparam int PW    = 1 + DW + 2 * TDATA_BYTES + TDEST_WIDTH + TUSER_WIDTH + TID_WIDTH;

    logic [MAP_WIDTH-1:0] field;
    logic                 hit;
    logic                 route_drop;
    logic [SEL_W-1:0]     sel;
    logic [TXN-1:0]       slot_free;
    logic [TXN-1:0]       load;
    logic [PW-1:0]        rx_bits;
    logic                 cnt_drop;
    logic                 cnt_route;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] lock, lock_nxt;

    assign field = (ROUTE_MODE == int'(ROUTE_TID))   ? MAP_WIDTH'(rx_tid)   :
                   (ROUTE_MODE == int'(ROUTE_TUSER)) ? MAP_WIDTH'(rx_tuser) :
                                                       MAP_WIDTH'(rx_tdest);

    assign slot_free = ~tx_tvalid | tx_tready;
    assign rx_bits   = {rx_tlast, rx_tdata, rx_tstrb, rx_tkeep, rx_tdest, rx_tuser, rx_tid};

    // Route lookup: scanning downward so the lowest matching entry is the last one written.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = OUTPUTS - 1; i >= 0; i--) begin
            if (MAP[i * MAP_WIDTH +: MAP_WIDTH] == field) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
        if (!hit && UNMAPPED == int'(UNMAPPED_EXTRACT)) begin
            sel = SEL_W'(OUTPUTS);
        end
        route_drop = !hit && (UNMAPPED == int'(UNMAPPED_DROP));
    end

    // Packet FSM: decides rx_tready, which slice loads, and which counter steps.
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock;
        rx_tready = 1'b0;
        load      = '0;
        cnt_drop  = 1'b0;
        cnt_route = 1'b0;
        if (!areset) begin
            case (state)
                IDLE: begin
                    if (route_drop) begin
                        rx_tready = 1'b1;
                        if (rx_tvalid) begin
                            if (rx_tlast) begin
                                cnt_drop = 1'b1;
                            end else begin
                                state_nxt = DROP;
                            end
                        end
                    end else begin
                        rx_tready = slot_free[sel];
                        if (rx_tvalid && slot_free[sel]) begin
                            load[sel] = 1'b1;
                            if (rx_tlast) begin
                                cnt_route = 1'b1;
                            end else begin
                                state_nxt = FORWARD;
                                lock_nxt  = sel;
                            end
                        end
                    end
                end
                FORWARD: begin
                    rx_tready = slot_free[lock];
                    if (rx_tvalid && slot_free[lock]) begin
                        load[lock] = 1'b1;
                        if (rx_tlast) begin
                            cnt_route = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                DROP: begin
                    rx_tready = 1'b1;
                    if (rx_tvalid && rx_tlast) begin
                        cnt_drop  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and locked route register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            lock  <= '0;
        end else begin
            state <= state_nxt;
            lock  <= lock_nxt;
        end
    end

    // Saturating status counters; each can step at most once per cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            dropped_packets <= '0;
            routed_packets  <= '0;
        end else begin
            if (cnt_drop && (dropped_packets != {COUNTER_WIDTH{1'b1}})) begin
                dropped_packets <= dropped_packets + 1'b1;
            end
            if (cnt_route && (routed_packets != {COUNTER_WIDTH{1'b1}})) begin
                routed_packets <= routed_packets + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < TXN; g++) begin : g_slice
        logic [PW-1:0] held;

        logic_axi4_stream_demux_packet_slice #(
            .WIDTH (PW)
        ) u_slice (
            .clk     (aclk),
            .rst     (areset),
            .load    (load[g]),
            .payload (rx_bits),
            .tvalid  (tx_tvalid[g]),
            .tready  (tx_tready[g]),
            .held    (held)
        );

        assign {tx_tlast[g],
                tx_tdata[g*DW +: DW],
                tx_tstrb[g*TDATA_BYTES +: TDATA_BYTES],
                tx_tkeep[g*TDATA_BYTES +: TDATA_BYTES],
                tx_tdest[g*TDEST_WIDTH +: TDEST_WIDTH],
                tx_tuser[g*TUSER_WIDTH +: TUSER_WIDTH],
                tx_tid[g*TID_WIDTH +: TID_WIDTH]} = held;
    end

endmodule

// File: tb/tb_logic_axi4_stream_demux_packet.sv
// tb/tb_logic_axi4_stream_demux_packet.sv - scoreboard bench for the packet demux (two configurations)
module tb_logic_axi4_stream_demux_packet;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [2:0]  dest;
        logic        user;
        logic [3:0]  id;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Config A: tdest routing, identity map over 4 outputs, unmapped beats extracted on tx[4].
    logic        a_rst;
    logic        a_rx_tvalid, a_rx_tready, a_rx_tlast;
    logic [31:0] a_rx_tdata;
    logic [3:0]  a_rx_tstrb, a_rx_tkeep;
    logic [2:0]  a_rx_tdest;
    logic        a_rx_tuser, a_rx_tid;
    logic [4:0]  a_tx_tvalid, a_tx_tready, a_tx_tlast;
    logic [159:0] a_tx_tdata;
    logic [19:0] a_tx_tstrb, a_tx_tkeep;
    logic [14:0] a_tx_tdest;
    logic [4:0]  a_tx_tuser, a_tx_tid;
    logic [15:0] a_dropped, a_routed;

    logic_axi4_stream_demux_packet #(
        .OUTPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(3), .TUSER_WIDTH(1), .TID_WIDTH(1),
        .ROUTE_MODE(0), .UNMAPPED(1), .COUNTER_WIDTH(16)
    ) dut_a (
        .aclk(aclk), .areset(a_rst),
        .rx_tvalid(a_rx_tvalid), .rx_tready(a_rx_tready), .rx_tlast(a_rx_tlast),
        .rx_tdata(a_rx_tdata), .rx_tstrb(a_rx_tstrb), .rx_tkeep(a_rx_tkeep),
        .rx_tdest(a_rx_tdest), .rx_tuser(a_rx_tuser), .rx_tid(a_rx_tid),
        .tx_tvalid(a_tx_tvalid), .tx_tready(a_tx_tready), .tx_tlast(a_tx_tlast),
        .tx_tdata(a_tx_tdata), .tx_tstrb(a_tx_tstrb), .tx_tkeep(a_tx_tkeep),
        .tx_tdest(a_tx_tdest), .tx_tuser(a_tx_tuser), .tx_tid(a_tx_tid),
        .dropped_packets(a_dropped), .routed_packets(a_routed)
    );

    // Config B: tid routing with MAP={5,9}, unmapped packets dropped, 2-bit counters.
    logic        b_rst;
    logic        b_rx_tvalid, b_rx_tready, b_rx_tlast;
    logic [31:0] b_rx_tdata;
    logic [3:0]  b_rx_tstrb, b_rx_tkeep;
    logic        b_rx_tdest, b_rx_tuser;
    logic [3:0]  b_rx_tid;
    logic [1:0]  b_tx_tvalid, b_tx_tready, b_tx_tlast;
    logic [63:0] b_tx_tdata;
    logic [7:0]  b_tx_tstrb, b_tx_tkeep;
    logic [1:0]  b_tx_tdest, b_tx_tuser;
    logic [7:0]  b_tx_tid;
    logic [1:0]  b_dropped, b_routed;

    logic_axi4_stream_demux_packet #(
        .OUTPUTS(2), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(4),
        .ROUTE_MODE(2), .MAP_WIDTH(4), .MAP(1024'h95), .UNMAPPED(0), .COUNTER_WIDTH(2)
    ) dut_b (
        .aclk(aclk), .areset(b_rst),
        .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready), .rx_tlast(b_rx_tlast),
        .rx_tdata(b_rx_tdata), .rx_tstrb(b_rx_tstrb), .rx_tkeep(b_rx_tkeep),
        .rx_tdest(b_rx_tdest), .rx_tuser(b_rx_tuser), .rx_tid(b_rx_tid),
        .tx_tvalid(b_tx_tvalid), .tx_tready(b_tx_tready), .tx_tlast(b_tx_tlast),
        .tx_tdata(b_tx_tdata), .tx_tstrb(b_tx_tstrb), .tx_tkeep(b_tx_tkeep),
        .tx_tdest(b_tx_tdest), .tx_tuser(b_tx_tuser), .tx_tid(b_tx_tid),
        .dropped_packets(b_dropped), .routed_packets(b_routed)
    );

    exp_t a_q [5][$];
    exp_t b_q [2][$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every completed tx handshake must match the head of that channel's queue.
    always @(negedge aclk) begin
        exp_t got;
        if (!a_rst) begin
            for (int i = 0; i < 5; i++) begin
                if (a_tx_tvalid[i] && a_tx_tready[i]) begin
                    got = '{last: a_tx_tlast[i], data: a_tx_tdata[i*32 +: 32],
                            strb: a_tx_tstrb[i*4 +: 4], keep: a_tx_tkeep[i*4 +: 4],
                            dest: a_tx_tdest[i*3 +: 3], user: a_tx_tuser[i], id: {3'b000, a_tx_tid[i]}};
                    if (a_q[i].size() == 0) begin
                        check($sformatf("a_unexpected_tx%0d", i), 64'(got), 64'hDEAD);
                    end else begin
                        check($sformatf("a_beat_tx%0d", i), 64'(got), 64'(a_q[i].pop_front()));
                    end
                end
            end
        end
        if (!b_rst) begin
            for (int i = 0; i < 2; i++) begin
                if (b_tx_tvalid[i] && b_tx_tready[i]) begin
                    got = '{last: b_tx_tlast[i], data: b_tx_tdata[i*32 +: 32],
                            strb: b_tx_tstrb[i*4 +: 4], keep: b_tx_tkeep[i*4 +: 4],
                            dest: {2'b00, b_tx_tdest[i]}, user: b_tx_tuser[i], id: b_tx_tid[i*4 +: 4]};
                    if (b_q[i].size() == 0) begin
                        check($sformatf("b_unexpected_tx%0d", i), 64'(got), 64'hDEAD);
                    end else begin
                        check($sformatf("b_beat_tx%0d", i), 64'(got), 64'(b_q[i].pop_front()));
                    end
                end
            end
        end
    end

    // Present one beat on A, queue its expectation on channel ch, wait for acceptance.
    task automatic a_send(input int ch, input logic [2:0] dest, input logic last, input logic [31:0] data);
        int n;
        a_rx_tvalid = 1'b1;
        a_rx_tlast  = last;
        a_rx_tdata  = data;
        a_rx_tstrb  = data[7:4];
        a_rx_tkeep  = data[11:8];
        a_rx_tdest  = dest;
        a_rx_tuser  = data[0];
        a_rx_tid    = data[1];
        if (ch >= 0) begin
            a_q[ch].push_back('{last: last, data: data, strb: data[7:4], keep: data[11:8],
                                dest: dest, user: data[0], id: {3'b000, data[1]}});
        end
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!a_rx_tready && n < 200);
        if (!a_rx_tready) check("a_accept_timeout", 64'd0, 64'd1);
        @(posedge aclk);
        #1;
    endtask

    // Present one beat on B; ch<0 means the beat must be dropped and accepted at once.
    task automatic b_send(input int ch, input logic [3:0] id, input logic last, input logic [31:0] data);
        int n;
        b_rx_tvalid = 1'b1;
        b_rx_tlast  = last;
        b_rx_tdata  = data;
        b_rx_tstrb  = data[7:4];
        b_rx_tkeep  = data[11:8];
        b_rx_tdest  = data[2];
        b_rx_tuser  = data[0];
        b_rx_tid    = id;
        if (ch >= 0) begin
            b_q[ch].push_back('{last: last, data: data, strb: data[7:4], keep: data[11:8],
                                dest: {2'b00, data[2]}, user: data[0], id: id});
        end
        n = 0;
        do begin
            @(negedge aclk);
            n++;
            if (ch < 0 && n == 1) check("b_drop_ready", 64'(b_rx_tready), 64'd1);
        end while (!b_rx_tready && n < 200);
        if (!b_rx_tready) check("b_accept_timeout", 64'd0, 64'd1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_rx_tvalid = 1'b0; a_rx_tlast = 1'b0; a_rx_tdata = '0; a_rx_tstrb = '0; a_rx_tkeep = '0;
        a_rx_tdest = '0; a_rx_tuser = 1'b0; a_rx_tid = 1'b0; a_tx_tready = '1;
        b_rx_tvalid = 1'b0; b_rx_tlast = 1'b0; b_rx_tdata = '0; b_rx_tstrb = '0; b_rx_tkeep = '0;
        b_rx_tdest = 1'b0; b_rx_tuser = 1'b0; b_rx_tid = '0; b_tx_tready = '1;
        @(posedge aclk);
        @(negedge aclk);
        check("a_reset_rx_tready", 64'(a_rx_tready), 64'd0);
        check("a_reset_tx_tvalid", 64'(a_tx_tvalid), 64'd0);
        check("a_reset_counters", {a_dropped, a_routed}, 64'd0);
        check("b_reset_rx_tready", 64'(b_rx_tready), 64'd0);
        check("b_reset_counters", {b_dropped, b_routed}, 64'd0);
        @(posedge aclk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // 3-beat packet to tx[2] then a single beat to tx[0]; one-cycle latency.
        a_send(2, 3'd2, 1'b0, 32'h1111_0A31);
        check("a_latency_tx2", 64'(a_tx_tvalid), 64'b00100);
        a_send(2, 3'd2, 1'b0, 32'h2222_0B52);
        a_send(2, 3'd2, 1'b1, 32'h3333_0C73);
        a_send(0, 3'd0, 1'b1, 32'h4444_0D94);
        a_rx_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("a_routed_after_t1", 64'(a_routed), 64'd2);

        // Route locked on first beat even though tdest changes mid-packet.
        a_send(1, 3'd1, 1'b0, 32'h5555_1E15);
        a_send(1, 3'd3, 1'b0, 32'h6666_2F26);
        a_send(1, 3'd3, 1'b0, 32'h7777_3A37);
        a_send(1, 3'd3, 1'b1, 32'h8888_4B48);
        a_rx_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("a_routed_after_t2", 64'(a_routed), 64'd3);

        // Prior packet on tx[0], then backpressure on tx[1] for 5 cycles.
        a_send(0, 3'd0, 1'b0, 32'h9999_5C59);
        a_send(0, 3'd0, 1'b1, 32'hAAAA_6D6A);
        a_tx_tready[1] = 1'b0;
        fork
            begin
                a_send(1, 3'd1, 1'b0, 32'hBBBB_7E7B);
                a_send(1, 3'd2, 1'b0, 32'hCCCC_8F8C);
                a_send(1, 3'd2, 1'b0, 32'hDDDD_9A9D);
                a_send(1, 3'd1, 1'b1, 32'hEEEE_AB0E);
                a_rx_tvalid = 1'b0;
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge aclk);
                    n++;
                end while (!a_tx_tvalid[1] && n < 50);
                check("a_bp_buffered", 64'(a_tx_tvalid[1]), 64'd1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge aclk);
                    check("a_bp_rx_tready", 64'(a_rx_tready), 64'd0);
                end
                @(posedge aclk);
                #1;
                a_tx_tready[1] = 1'b1;
            end
        join
        repeat (3) @(posedge aclk);
        #1;
        check("a_routed_after_t3", 64'(a_routed), 64'd5);

        // Unmapped tdest=7 goes to the extract port tx[4].
        a_send(4, 3'd7, 1'b0, 32'h0F0F_1C21);
        a_send(4, 3'd7, 1'b0, 32'hF0F0_2D42);
        a_send(4, 3'd7, 1'b1, 32'h1234_3E63);
        a_rx_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("a_routed_after_t4", 64'(a_routed), 64'd6);
        check("a_dropped_extract", 64'(a_dropped), 64'd0);

        // Reset mid-packet with a beat stalled in slice 2.
        a_tx_tready[2] = 1'b0;
        a_send(2, 3'd2, 1'b0, 32'h5678_4F84);
        a_rx_tdest = 3'd2;
        a_rx_tlast = 1'b0;
        @(negedge aclk);
        check("a_stalled_tx2", 64'(a_tx_tvalid), 64'b00100);
        check("a_stalled_rx_tready", 64'(a_rx_tready), 64'd0);
        a_q[2].delete();
        @(posedge aclk);
        #1;
        a_rst = 1'b1;
        a_rx_tvalid = 1'b0;
        @(negedge aclk);
        check("a_midreset_rx_tready", 64'(a_rx_tready), 64'd0);
        @(posedge aclk);
        #1;
        a_rst = 1'b0;
        check("a_midreset_tx_tvalid", 64'(a_tx_tvalid), 64'd0);
        check("a_midreset_counters", {a_dropped, a_routed}, 64'd0);
        a_tx_tready[2] = 1'b1;
        a_send(0, 3'd0, 1'b1, 32'h9ABC_5A05);
        a_rx_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("a_routed_after_reset", 64'(a_routed), 64'd1);

        // Config B: tid routing through MAP={5,9}.
        b_send(1, 4'd9, 1'b1, 32'hCAFE_1B11);
        b_send(0, 4'd5, 1'b0, 32'hBEEF_2C22);
        b_send(0, 4'd5, 1'b1, 32'hF00D_3D33);
        b_rx_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("b_routed_2", 64'(b_routed), 64'd2);

        // Multi-beat drop: counter steps only on the last beat.
        b_send(-1, 4'd3, 1'b0, 32'h0101_4E44);
        b_send(-1, 4'd9, 1'b0, 32'h0202_5F55);
        check("b_dropped_mid", 64'(b_dropped), 64'd0);
        b_send(-1, 4'd5, 1'b1, 32'h0303_6A66);
        b_rx_tvalid = 1'b0;
        check("b_dropped_1", 64'(b_dropped), 64'd1);

        // Single-beat drops saturate the 2-bit counter at 3.
        for (int k = 2; k <= 5; k++) begin
            b_send(-1, 4'd7, 1'b1, 32'h0400_0000 + 32'(k));
            check($sformatf("b_dropped_%0d", k), 64'(b_dropped), 64'((k > 3) ? 3 : k));
        end
        b_rx_tvalid = 1'b0;

        // Routed counter saturates too.
        for (int k = 3; k <= 5; k++) begin
            b_send(1, 4'd9, 1'b1, 32'h0500_0000 + 32'(k));
            check($sformatf("b_routed_%0d", k), 64'(b_routed), 64'((k > 3) ? 3 : k));
        end
        b_rx_tvalid = 1'b0;

        repeat (5) @(posedge aclk);
        @(negedge aclk);
        for (int i = 0; i < 5; i++) check($sformatf("a_leftover_tx%0d", i), 64'(a_q[i].size()), 64'd0);
        for (int i = 0; i < 2; i++) check($sformatf("b_leftover_tx%0d", i), 64'(b_q[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
